// File: rtl/fb_pixel_writer_pkg.sv
// Shared types and constants for the framebuffer pixel writer path.
package fb_pixel_writer_pkg;

  localparam int unsigned NibbleW   = 4;
  localparam int unsigned DefFrameW = 320;
  localparam int unsigned DefFrameH = 480;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPtr   = 3'd1,
    StPtrW  = 3'd2,
    StLoad  = 3'd3,
    StSend  = 3'd4,
    StWait  = 3'd5,
    StDone  = 3'd6
  } state_e;

endpackage

// File: rtl/fb_sync_fifo.sv
// Small synchronous FIFO with flush; full/empty derived from a registered occupancy count.
import fb_pixel_writer_pkg::*;

module fb_sync_fifo #(
  parameter int unsigned WIDTH = NibbleW,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Buffers grey pixels from the iteration engine and streams them to the RP2040 over a
// toggle req/ack handshake, preceded by one write-pointer-reset transaction per frame.
import fb_pixel_writer_pkg::*;

module fb_pixel_writer #(
  parameter int unsigned FRAME_W     = DefFrameW,
  parameter int unsigned FRAME_H     = DefFrameH,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_frame_i,
  input  logic               pix_valid_i,
  input  logic [NibbleW-1:0] pix_data_i,
  output logic               pix_ready_o,
  output logic [NibbleW-1:0] write_data_o,
  output logic               reset_write_ptr_o,
  output logic               write_req_o,
  input  logic               ack_i,
  output logic               busy_o,
  output logic               frame_done_o
);

  localparam int unsigned NumPix = FRAME_W * FRAME_H;
  localparam int unsigned CntW   = $clog2(NumPix + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s, pending;
  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [NibbleW-1:0]     wdata_q, fifo_head;
  logic                   ptr_q, req_q, done_q;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;

  // ack_i crosses from the RP2040 domain; no reset so it tracks the far side immediately.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
  end

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign pending = req_q ^ ack_s;

  assign busy_o            = (state_q != StIdle);
  assign pix_ready_o       = busy_o & ~fifo_full & (state_q != StDone);
  assign write_data_o      = wdata_q;
  assign reset_write_ptr_o = ptr_q;
  assign write_req_o       = req_q;
  assign frame_done_o      = done_q;

  assign fifo_push  = pix_valid_i & pix_ready_o;
  assign fifo_pop   = (state_q == StLoad) & ~fifo_empty;
  assign fifo_flush = (state_q == StIdle) & start_frame_i;

  fb_sync_fifo #(
    .WIDTH (NibbleW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (pix_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wdata_q <= '0;
      ptr_q   <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // Follow the far side so a reset never leaves a spurious transaction pending.
          req_q <= ack_s;
          if (start_frame_i) begin
            cnt_q   <= '0;
            ptr_q   <= 1'b1;
            wdata_q <= '0;
            state_q <= StPtr;
          end
        end
        StPtr: begin
          req_q   <= ~req_q;
          state_q <= StPtrW;
        end
        StPtrW: begin
          if (!pending) begin
            ptr_q   <= 1'b0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (!fifo_empty) begin
            wdata_q <= fifo_head;
            state_q <= StSend;
          end
        end
        StSend: begin
          req_q   <= ~req_q;
          state_q <= StWait;
        end
        StWait: begin
          if (!pending) begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(NumPix - 1)) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench: RP2040 modelled as a delayed toggle responder, frames checked as streams.
module tb_fb_pixel_writer;

  localparam int unsigned FW   = 4;
  localparam int unsigned FH   = 2;
  localparam int unsigned NPIX = FW * FH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_frame = 1'b0;
  logic       pix_valid = 1'b0;
  logic [3:0] pix_data = 4'h0;
  logic       ack = 1'b0;
  logic       pix_ready, reset_ptr, write_req, busy, frame_done;
  logic [3:0] write_data;

  int n_checks = 0;
  int n_fail   = 0;

  bit rp_en    = 1'b0;
  int rp_fixed = 0;
  int rp_cnt   = 0;
  int done_cnt = 0;

  logic [3:0] tx_data[$];
  logic       tx_ptr[$];
  logic [3:0] acc_q[$];
  logic [3:0] exp_px[$];

  fb_pixel_writer #(
    .FRAME_W     (FW),
    .FRAME_H     (FH),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_frame_i     (start_frame),
    .pix_valid_i       (pix_valid),
    .pix_data_i        (pix_data),
    .pix_ready_o       (pix_ready),
    .write_data_o      (write_data),
    .reset_write_ptr_o (reset_ptr),
    .write_req_o       (write_req),
    .ack_i             (ack),
    .busy_o            (busy),
    .frame_done_o      (frame_done)
  );

  always #5 clk = ~clk;

  // RP2040: latch the transaction when req differs from ack, answer after a delay.
  initial begin
    forever begin
      @(negedge clk);
      if (rp_cnt > 0) begin
        rp_cnt--;
        if (rp_cnt == 0) ack = ~ack;
      end else if (rp_en && write_req !== ack) begin
        tx_data.push_back(write_data);
        tx_ptr.push_back(reset_ptr);
        rp_cnt = (rp_fixed != 0) ? rp_fixed : int'($urandom_range(20, 3));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pix_valid === 1'b1 && pix_ready === 1'b1) acc_q.push_back(pix_data);
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  // -1 when transactions are [ptr reset, exp_px...] and accepted pixels equal exp_px.
  function automatic int stream_err();
    if (tx_data.size() != exp_px.size() + 1) return -2;
    if (tx_ptr[0] !== 1'b1 || tx_data[0] !== 4'h0) return 0;
    for (int i = 0; i < exp_px.size(); i++)
      if (tx_ptr[i+1] !== 1'b0 || tx_data[i+1] !== exp_px[i]) return i + 1;
    if (acc_q.size() != exp_px.size()) return -3;
    for (int i = 0; i < exp_px.size(); i++)
      if (acc_q[i] !== exp_px[i]) return 100 + i;
    return -1;
  endfunction

  task automatic start_pulse();
    @(posedge clk); #1 start_frame = 1'b1;
    @(posedge clk); #1 start_frame = 1'b0;
  endtask

  task automatic send_pixel(input logic [3:0] v);
    pix_valid = 1'b1;
    pix_data  = v;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (pix_ready === 1'b1) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL send_pixel: pixel %h not accepted, ready=%b required 1", v, pix_ready);
  endtask

  task automatic wait_drained(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (tx_data.size() == n && rp_cnt == 0 && write_req === ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_pixels(input int stall_at, input int stall_len);
    bit ok;
    for (int i = 0; i < exp_px.size(); i++) begin
      if (i == stall_at) begin
        pix_valid = 1'b0;
        wait_drained(i + 1, ok);
        repeat (stall_len) @(posedge clk);
        #1;
      end
      send_pixel(exp_px[i]);
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output logic busy_after);
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic run_frame(input int stall_at, input int stall_len, output bit ok,
                           output logic busy_after);
    tx_data.delete(); tx_ptr.delete(); acc_q.delete();
    done_cnt = 0;
    start_pulse();
    fork
      drive_pixels(stall_at, stall_len);
      wait_done(ok, busy_after);
    join
    repeat (5) @(negedge clk);
  endtask

  task automatic rand_pixels();
    exp_px.delete();
    for (int i = 0; i < NPIX; i++) exp_px.push_back(4'($urandom_range(15, 0)));
  endtask

  task automatic test_reset();
    ack   = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({write_req, busy, frame_done, pix_ready, reset_ptr, write_data} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b busy=%b done=%b rdy=%b ptr=%b data=%h, required all 0",
               write_req, busy, frame_done, pix_ready, reset_ptr, write_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (write_req !== 1'b1 || busy !== 1'b0 || pix_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_realign: got req=%b busy=%b rdy=%b, required req=1 busy=0 rdy=0",
               write_req, busy, pix_ready);
    end
    rp_en = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (tx_data.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_no_tx: got %0d transactions, required 0", tx_data.size());
    end
  endtask

  task automatic test_frame_basic();
    bit ok; logic b; int e;
    exp_px.delete();
    for (int i = 0; i < NPIX; i++) exp_px.push_back(4'(i + 1));
    rp_fixed = 0;
    run_frame(-1, 0, ok, b);
    e = stream_err();
    n_checks++;
    if (!ok || done_cnt !== 1 || b !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got seen=%b pulses=%0d busy_after=%b, required 1/1/0", ok, done_cnt, b);
    end
    n_checks++;
    if (e !== -1) begin
      n_fail++;
      $display("FAIL basic_stream: got error code %0d (tx=%0d acc=%0d), required -1",
               e, tx_data.size(), acc_q.size());
    end
  endtask

  task automatic test_stall();
    bit ok, dr; logic b; int e, tog, n0; logic r;
    rand_pixels();
    rp_fixed = 0;
    tog = 0; n0 = 0; r = 1'b0; dr = 1'b0;
    fork
      run_frame(4, 50, ok, b);
      begin
        wait_drained(5, dr);
        repeat (5) @(negedge clk);
        r  = write_req;
        n0 = tx_data.size();
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (write_req !== r) tog++;
        end
        n_checks++;
        if (!dr || tog !== 0 || tx_data.size() !== n0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: drained=%b toggles=%0d tx %0d->%0d busy=%b, required 1/0/same/1",
                   dr, tog, n0, tx_data.size(), busy);
        end
      end
    join
    e = stream_err();
    n_checks++;
    if (!ok || done_cnt !== 1 || e !== -1) begin
      n_fail++;
      $display("FAIL stall_stream: got seen=%b pulses=%0d err=%0d, required 1/1/-1", ok, done_cnt, e);
    end
  endtask

  task automatic test_slow_ack();
    bit ok; logic b; int e;
    rand_pixels();
    rp_fixed = 200;
    fork
      run_frame(-1, 0, ok, b);
      begin
        repeat (60) @(negedge clk);
        n_checks++;
        if (acc_q.size() !== 4 || pix_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL slow_full: got accepted=%0d ready=%b, required 4/0", acc_q.size(), pix_ready);
        end
      end
    join
    rp_fixed = 0;
    e = stream_err();
    n_checks++;
    if (!ok || done_cnt !== 1 || b !== 1'b0 || e !== -1) begin
      n_fail++;
      $display("FAIL slow_stream: got seen=%b pulses=%0d busy_after=%b err=%0d, required 1/1/0/-1",
               ok, done_cnt, b, e);
    end
  endtask

  task automatic test_start_in_wait();
    bit ok, hit; logic b; int e;
    rand_pixels();
    rp_fixed = 0;
    hit = 1'b0;
    fork
      run_frame(-1, 0, ok, b);
      begin
        for (int c = 0; c < 2000; c++) begin
          @(negedge clk);
          if (tx_data.size() == 4 && rp_cnt > 0) begin
            hit = 1'b1;
            break;
          end
        end
        @(posedge clk); #1 start_frame = 1'b1;
        @(posedge clk); #1 start_frame = 1'b0;
      end
    join
    e = stream_err();
    n_checks++;
    if (!hit || !ok || done_cnt !== 1 || e !== -1 || b !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_wait: got hit=%b seen=%b pulses=%0d err=%0d busy_after=%b, required 1/1/1/-1/0",
               hit, ok, done_cnt, e, b);
    end
  endtask

  task automatic test_reset_mid();
    bit hit; int n0, dc, tog; logic r;
    tx_data.delete(); tx_ptr.delete(); acc_q.delete();
    done_cnt = 0;
    rp_fixed = 60;
    hit = 1'b0;
    start_pulse();
    for (int i = 0; i < 3; i++) send_pixel(4'($urandom_range(15, 0)));
    pix_valid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (tx_data.size() == 3 && rp_cnt > 0) begin
        hit = 1'b1;
        break;
      end
    end
    rp_en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = tx_data.size();
    dc = done_cnt;
    @(negedge clk);
    n_checks++;
    if (!hit || busy !== 1'b0 || pix_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: got hit=%b busy=%b rdy=%b, required 1/0/0", hit, busy, pix_ready);
    end
    for (int c = 0; c < 500 && rp_cnt != 0; c++) @(negedge clk);
    repeat (10) @(negedge clk);
    n_checks++;
    if (write_req !== ack || rp_cnt !== 0) begin
      n_fail++;
      $display("FAIL rstmid_realign: got req=%b ack=%b rp_cnt=%0d, required req==ack, 0",
               write_req, ack, rp_cnt);
    end
    r = write_req;
    tog = 0;
    rp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (write_req !== r) tog++;
    end
    n_checks++;
    if (tog !== 0 || tx_data.size() !== n0 || done_cnt !== dc || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got toggles=%0d tx=%0d pulses=%0d busy=%b, required 0/%0d/%0d/0",
               tog, tx_data.size(), done_cnt, busy, n0, dc);
    end
    rp_fixed = 0;
  endtask

  task automatic test_recovery();
    bit ok; logic b; int e;
    rand_pixels();
    run_frame(-1, 0, ok, b);
    e = stream_err();
    n_checks++;
    if (!ok || done_cnt !== 1 || b !== 1'b0 || e !== -1) begin
      n_fail++;
      $display("FAIL recovery: got seen=%b pulses=%0d busy_after=%b err=%0d, required 1/1/0/-1",
               ok, done_cnt, b, e);
    end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_stall();
    test_slow_ack();
    test_start_in_wait();
    test_reset_mid();
    test_recovery();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
